regfile_wb_scheduler: RTL and testbench
=======================================

Name: regfile_wb_scheduler

Overview:
Schedules the register file's single write port among three writeback sources: ALU (0), load/store unit (1) and CSR unit (2).
- Each source uses a valid/ready handshake.
- The granted write is registered onto the register file write port.
- A 32-entry pending-write scoreboard tells the decoder which source registers have an outstanding write, so issue can stall.
- Sits between the execute/memory/CSR units and register_file in the RV32I_Zicsr core.

Parameters:
RR_EN, 1, 1 = round-robin arbitration among sources; 0 = fixed priority ALU > LSU > CSR.
Widths come from header.vh: `XLEN (32), `XADDR (5), `REGISTERS (32).

Ports:
i_clk  in  1  CPU clock
i_rst_n  in  1  reset, synchronous, active-low
i_alu_valid / i_lsu_valid / i_csr_valid  in  1 each  source has a writeback pending
i_alu_rd / i_lsu_rd / i_csr_rd  in  `XADDR each  destination register
i_alu_data / i_lsu_data / i_csr_data  in  `XLEN each  writeback data
o_alu_ready / o_lsu_ready / o_csr_ready  out  1 each  source's writeback is accepted this cycle
i_issue_valid  in  1  an instruction writing rd issues this cycle
i_issue_rd  in  `XADDR  that instruction's destination
i_flush  in  1  pipeline flush, clears the scoreboard
i_rs1_addr, i_rs2_addr  in  `XADDR  decoder source operands
o_rs1_busy, o_rs2_busy  out  1  operand has a pending write
o_wr_en  out  1  register file write enable (registered)
o_rd_addr  out  `XADDR  register file write address (registered)
o_rd_data  out  `XLEN  register file write data (registered)

Behaviour:
- Reset (i_rst_n=0 at posedge): o_wr_en=0, o_rd_addr=0, o_rd_data=0, all pending bits 0, rr_ptr=0. All o_*_ready are forced 0 while i_rst_n=0. Any in-flight request is dropped; the source must re-present it.
- Grant (combinational):
  - At most one o_*_ready is high, and only for a source whose valid is high. A transfer occurs when valid && ready.
  - The port never backpressures, so some source is always granted when any valid is high.
- RR_EN=1:
  - Search order starts at rr_ptr (2 bits, values 0..2) and wraps 2 -> 0.
  - On a grant to source k, rr_ptr <= (k+1) mod 3. With no grant, rr_ptr holds.
- RR_EN=0: fixed priority ALU > LSU > CSR; rr_ptr is unused.
- Sources must hold valid, rd and data stable until ready. The scheduler does not check this.
- Write stage (latency 1): at the edge following a grant to source k, the write-port registers load:
  - o_wr_en <= (rd_k != 0)
  - o_rd_addr <= rd_k
  - o_rd_data <= data_k
  - With no grant, o_wr_en <= 0 and addr/data hold.
  - A grant with rd=0 is accepted (ready high) but produces o_wr_en=0 and touches no pending bit.
- Scoreboard pending[31:0]. Updates apply at the posedge, in this precedence:
  - i_flush=1: every bit cleared. Both the issue and the grant clear are ignored that cycle. The write stage still loads normally, so an in-flight write completes.
  - Otherwise, a grant with rd_k != 0 clears pending[rd_k] at the same edge the write stage loads.
  - Issue with i_issue_rd != 0 sets pending[i_issue_rd].
  - Issue set and grant clear of the same register in one cycle: set wins, because the newer instruction owns the register.
  - Bit 0 is hard-wired 0.
- Busy outputs (combinational): o_rs1_busy = pending[i_rs1_addr] and o_rs2_busy = pending[i_rs2_addr]. Address 0 always reads 0.
- Coherence: a register's pending bit drops on the same edge that o_wr_en rises for it. The register file's rd-forwarding supplies the data to a reader in that cycle, so no stale-data window exists.
- Re-issuing to an already-pending register keeps the bit set. The first writeback to that register clears it; the decoder must not issue a second writer to a pending rd.

Decomposition:
- header.vh gains:
  - `WB_SRC_ALU 0, `WB_SRC_LSU 1, `WB_SRC_CSR 2
  - `NWB 3
- One sub-module, wb_rr_arbiter: valid vector in, one-hot grant out, owns rr_ptr, honours RR_EN.
- The scoreboard and write stage stay in regfile_wb_scheduler.

Test Plan:
1. Reset: i_rst_n=0 for 2 cycles with all valids=1 -> all ready=0, o_wr_en=0, busy=0. After release, ALU is granted first (rr_ptr=0).
2. Round-robin, RR_EN=1: all three valid continuously, rd=5/6/7 -> grants ALU, LSU, CSR, ALU. o_wr_en=1 each cycle with o_rd_addr 5, 6, 7, 5, each one cycle after its grant.
3. Fixed priority, RR_EN=0: ALU and CSR both valid for 3 cycles -> ALU granted all 3 cycles, CSR ready stays 0.
4. Scoreboard: issue rd=10 -> o_rs1_busy=1 for i_rs1_addr=10. LSU writes rd=10 data 0xDEADBEEF -> busy drops on the same edge o_wr_en=1, o_rd_addr=10, o_rd_data=0xDEADBEEF.
5. Simultaneous: in one cycle issue rd=3 and grant ALU with rd=3 -> pending[3] stays 1 and o_wr_en=1 next cycle. Separately, issue rd=0 -> no pending bit set. A grant with rd=0 -> ready=1, o_wr_en=0.
6. Flush: pending {4,9}; in one cycle assert i_flush, issue rd=12, and grant rd=4 -> all busy=0 afterwards, and o_wr_en=1 with o_rd_addr=4 next cycle.

Source files
------------

// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared widths, writeback source indices and arbiter pointer encoding
// for the register file writeback scheduler.
package regfile_wb_scheduler_pkg;

    localparam int XLEN      = 32;
    localparam int XADDR     = 5;
    localparam int REGISTERS = 32;

    // Writeback source indices; bit k of valid/grant vectors is source k.
    localparam int WB_SRC_ALU = 0;
    localparam int WB_SRC_LSU = 1;
    localparam int WB_SRC_CSR = 2;
    localparam int NWB        = 3;

    // Round-robin pointer: the source searched first in the current cycle.
    typedef enum logic [1:0] {
        PTR_ALU = 2'd0,
        PTR_LSU = 2'd1,
        PTR_CSR = 2'd2
    } rr_ptr_e;

endpackage

// File: rtl/regfile_wb_scheduler_if.sv
// Bundle of writeback source handshakes, issue/flush, decoder operand
// lookups and the registered register-file write port.
//
// Handshake: a source raises i_*_valid with rd/data and holds all three
// stable until its o_*_ready is high; a transfer happens on a rising clock
// edge where valid && ready. Ready is combinational from the valids, at most
// one ready is high per cycle, and ready is never high without valid.
interface regfile_wb_scheduler_if;
    import regfile_wb_scheduler_pkg::*;

    logic             i_alu_valid;
    logic             i_lsu_valid;
    logic             i_csr_valid;
    logic [XADDR-1:0] i_alu_rd;
    logic [XADDR-1:0] i_lsu_rd;
    logic [XADDR-1:0] i_csr_rd;
    logic [XLEN-1:0]  i_alu_data;
    logic [XLEN-1:0]  i_lsu_data;
    logic [XLEN-1:0]  i_csr_data;
    logic             o_alu_ready;
    logic             o_lsu_ready;
    logic             o_csr_ready;

    logic             i_issue_valid;
    logic [XADDR-1:0] i_issue_rd;
    logic             i_flush;

    logic [XADDR-1:0] i_rs1_addr;
    logic [XADDR-1:0] i_rs2_addr;
    logic             o_rs1_busy;
    logic             o_rs2_busy;

    logic             o_wr_en;
    logic [XADDR-1:0] o_rd_addr;
    logic [XLEN-1:0]  o_rd_data;

    // Arbiter pointer state, visible for debug and checkers.
    rr_ptr_e          dbg_rr_ptr;

    modport slave (
        input  i_alu_valid, i_lsu_valid, i_csr_valid,
        input  i_alu_rd, i_lsu_rd, i_csr_rd,
        input  i_alu_data, i_lsu_data, i_csr_data,
        output o_alu_ready, o_lsu_ready, o_csr_ready,
        input  i_issue_valid, i_issue_rd, i_flush,
        input  i_rs1_addr, i_rs2_addr,
        output o_rs1_busy, o_rs2_busy,
        output o_wr_en, o_rd_addr, o_rd_data,
        output dbg_rr_ptr
    );

    modport master (
        output i_alu_valid, i_lsu_valid, i_csr_valid,
        output i_alu_rd, i_lsu_rd, i_csr_rd,
        output i_alu_data, i_lsu_data, i_csr_data,
        input  o_alu_ready, o_lsu_ready, o_csr_ready,
        output i_issue_valid, i_issue_rd, i_flush,
        output i_rs1_addr, i_rs2_addr,
        input  o_rs1_busy, o_rs2_busy,
        input  o_wr_en, o_rd_addr, o_rd_data,
        input  dbg_rr_ptr
    );

endinterface

// File: rtl/regfile_wb_scheduler_wb_rr_arbiter.sv
// Three-way writeback arbiter: valid vector in, one-hot grant out.
// Round-robin when RR_EN=1, fixed priority ALU > LSU > CSR otherwise.
module wb_rr_arbiter
    import regfile_wb_scheduler_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic [NWB-1:0] i_valid,
    output logic [NWB-1:0] o_grant,
    output rr_ptr_e        o_rr_ptr
);

    rr_ptr_e rr_ptr;
    rr_ptr_e rr_ptr_next;
    rr_ptr_e ptr_eff;

    // Pointer register: restarts at ALU on reset, otherwise follows the last grant.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            rr_ptr <= PTR_ALU;
        end else begin
            rr_ptr <= rr_ptr_next;
        end
    end

    // Grant selection and pointer advance; no grant at all while in reset.
    always_comb begin
        o_grant     = '0;
        rr_ptr_next = rr_ptr;
        ptr_eff     = RR_EN ? rr_ptr : PTR_ALU;
        if (i_rst_n) begin
            case (ptr_eff)
                PTR_LSU: begin
                    if (i_valid[WB_SRC_LSU])      o_grant[WB_SRC_LSU] = 1'b1;
                    else if (i_valid[WB_SRC_CSR]) o_grant[WB_SRC_CSR] = 1'b1;
                    else if (i_valid[WB_SRC_ALU]) o_grant[WB_SRC_ALU] = 1'b1;
                end
                PTR_CSR: begin
                    if (i_valid[WB_SRC_CSR])      o_grant[WB_SRC_CSR] = 1'b1;
                    else if (i_valid[WB_SRC_ALU]) o_grant[WB_SRC_ALU] = 1'b1;
                    else if (i_valid[WB_SRC_LSU]) o_grant[WB_SRC_LSU] = 1'b1;
                end
                default: begin
                    if (i_valid[WB_SRC_ALU])      o_grant[WB_SRC_ALU] = 1'b1;
                    else if (i_valid[WB_SRC_LSU]) o_grant[WB_SRC_LSU] = 1'b1;
                    else if (i_valid[WB_SRC_CSR]) o_grant[WB_SRC_CSR] = 1'b1;
                end
            endcase
            // The winner moves to the back of the search order.
            if (RR_EN) begin
                if (o_grant[WB_SRC_ALU])      rr_ptr_next = PTR_LSU;
                else if (o_grant[WB_SRC_LSU]) rr_ptr_next = PTR_CSR;
                else if (o_grant[WB_SRC_CSR]) rr_ptr_next = PTR_ALU;
            end
        end
    end

    assign o_rr_ptr = rr_ptr;

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Register file writeback scheduler: arbitrates ALU/LSU/CSR writebacks onto
// the single registered write port and tracks pending writes per register
// so the decoder can stall on busy source operands.
module regfile_wb_scheduler
    import regfile_wb_scheduler_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    regfile_wb_scheduler_if.slave wb
);

    logic [NWB-1:0]       valid_vec;
    logic [NWB-1:0]       grant;
    rr_ptr_e              rr_ptr;
    logic                 gnt_any;
    logic [XADDR-1:0]     gnt_rd;
    logic [XLEN-1:0]      gnt_data;
    logic [REGISTERS-1:0] pending_q;
    logic [REGISTERS-1:0] pending_d;

    assign valid_vec[WB_SRC_ALU] = wb.i_alu_valid;
    assign valid_vec[WB_SRC_LSU] = wb.i_lsu_valid;
    assign valid_vec[WB_SRC_CSR] = wb.i_csr_valid;

    wb_rr_arbiter #(
        .RR_EN    (RR_EN)
    ) u_arb (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_valid  (valid_vec),
        .o_grant  (grant),
        .o_rr_ptr (rr_ptr)
    );

    assign wb.o_alu_ready = grant[WB_SRC_ALU];
    assign wb.o_lsu_ready = grant[WB_SRC_LSU];
    assign wb.o_csr_ready = grant[WB_SRC_CSR];
    assign wb.dbg_rr_ptr  = rr_ptr;

    // Select the granted source's destination and data.
    always_comb begin
        gnt_any  = 1'b0;
        gnt_rd   = '0;
        gnt_data = '0;
        if (grant[WB_SRC_ALU]) begin
            gnt_any  = 1'b1;
            gnt_rd   = wb.i_alu_rd;
            gnt_data = wb.i_alu_data;
        end else if (grant[WB_SRC_LSU]) begin
            gnt_any  = 1'b1;
            gnt_rd   = wb.i_lsu_rd;
            gnt_data = wb.i_lsu_data;
        end else if (grant[WB_SRC_CSR]) begin
            gnt_any  = 1'b1;
            gnt_rd   = wb.i_csr_rd;
            gnt_data = wb.i_csr_data;
        end
    end

    // Write stage: one cycle after a grant; writes to x0 are accepted but not enabled.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wb.o_wr_en   <= 1'b0;
            wb.o_rd_addr <= '0;
            wb.o_rd_data <= '0;
        end else if (gnt_any) begin
            wb.o_wr_en   <= (gnt_rd != '0);
            wb.o_rd_addr <= gnt_rd;
            wb.o_rd_data <= gnt_data;
        end else begin
            wb.o_wr_en   <= 1'b0;
        end
    end

    // Scoreboard next state: flush beats everything, then a new issue beats
    // a completing write to the same register since the newer instruction owns it.
    always_comb begin
        pending_d = pending_q;
        if (wb.i_flush) begin
            pending_d = '0;
        end else begin
            if (gnt_any && (gnt_rd != '0)) begin
                pending_d[gnt_rd] = 1'b0;
            end
            if (wb.i_issue_valid && (wb.i_issue_rd != '0)) begin
                pending_d[wb.i_issue_rd] = 1'b1;
            end
        end
        pending_d[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    // Operand busy lookups; x0 reads 0 because bit 0 never sets.
    assign wb.o_rs1_busy = pending_q[wb.i_rs1_addr];
    assign wb.o_rs2_busy = pending_q[wb.i_rs2_addr];

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Bench for regfile_wb_scheduler: one round-robin and one fixed-priority
// instance share the same stimulus. Directed vectors carry hand-derived
// expectations; every cycle is also checked against a behavioural model.
module tb_regfile_wb_scheduler;
    import regfile_wb_scheduler_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [2:0]  valid;
    logic [4:0]  rd   [3];
    logic [31:0] data [3];
    logic        issue_v;
    logic [4:0]  issue_rd;
    logic        flush;
    logic [4:0]  rs1;
    logic [4:0]  rs2;

    regfile_wb_scheduler_if if_rr ();
    regfile_wb_scheduler_if if_fp ();

    assign if_rr.i_alu_valid   = valid[0];
    assign if_rr.i_lsu_valid   = valid[1];
    assign if_rr.i_csr_valid   = valid[2];
    assign if_rr.i_alu_rd      = rd[0];
    assign if_rr.i_lsu_rd      = rd[1];
    assign if_rr.i_csr_rd      = rd[2];
    assign if_rr.i_alu_data    = data[0];
    assign if_rr.i_lsu_data    = data[1];
    assign if_rr.i_csr_data    = data[2];
    assign if_rr.i_issue_valid = issue_v;
    assign if_rr.i_issue_rd    = issue_rd;
    assign if_rr.i_flush       = flush;
    assign if_rr.i_rs1_addr    = rs1;
    assign if_rr.i_rs2_addr    = rs2;

    assign if_fp.i_alu_valid   = valid[0];
    assign if_fp.i_lsu_valid   = valid[1];
    assign if_fp.i_csr_valid   = valid[2];
    assign if_fp.i_alu_rd      = rd[0];
    assign if_fp.i_lsu_rd      = rd[1];
    assign if_fp.i_csr_rd      = rd[2];
    assign if_fp.i_alu_data    = data[0];
    assign if_fp.i_lsu_data    = data[1];
    assign if_fp.i_csr_data    = data[2];
    assign if_fp.i_issue_valid = issue_v;
    assign if_fp.i_issue_rd    = issue_rd;
    assign if_fp.i_flush       = flush;
    assign if_fp.i_rs1_addr    = rs1;
    assign if_fp.i_rs2_addr    = rs2;

    regfile_wb_scheduler #(.RR_EN(1'b1)) dut_rr (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .wb      (if_rr)
    );

    regfile_wb_scheduler #(.RR_EN(1'b0)) dut_fp (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .wb      (if_fp)
    );

    // ---------------- scoreboard / reference model ----------------
    int n_checks = 0;
    int n_errors = 0;

    // Model index 0 = round-robin instance, 1 = fixed-priority instance.
    logic [31:0] m_pending [2];
    int          m_ptr     [2];
    logic        m_wr_en   [2];
    logic [4:0]  m_addr    [2];
    logic [31:0] m_data    [2];
    int          m_grant   [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            m_pending[d] = '0;
            m_ptr[d]     = 0;
            m_wr_en[d]   = 1'b0;
            m_addr[d]    = '0;
            m_data[d]    = '0;
        end
    endfunction

    // Which source wins this cycle, or -1 when none.
    function automatic int model_pick(input int d);
        int start;
        start = (d == 0) ? m_ptr[0] : 0;
        for (int i = 0; i < 3; i++) begin
            if (valid[(start + i) % 3]) return (start + i) % 3;
        end
        return -1;
    endfunction

    function automatic logic [2:0] dut_ready(input int d);
        if (d == 0) return {if_rr.o_csr_ready, if_rr.o_lsu_ready, if_rr.o_alu_ready};
        return {if_fp.o_csr_ready, if_fp.o_lsu_ready, if_fp.o_alu_ready};
    endfunction

    function automatic logic [1:0] dut_busy(input int d);
        if (d == 0) return {if_rr.o_rs2_busy, if_rr.o_rs1_busy};
        return {if_fp.o_rs2_busy, if_fp.o_rs1_busy};
    endfunction

    function automatic logic [37:0] dut_port(input int d);
        if (d == 0) return {if_rr.o_wr_en, if_rr.o_rd_addr, if_rr.o_rd_data};
        return {if_fp.o_wr_en, if_fp.o_rd_addr, if_fp.o_rd_data};
    endfunction

    // One clock: compare combinational outputs, advance, compare registered outputs.
    task automatic step();
        logic [2:0] exp_rdy;
        logic [1:0] exp_busy;
        logic [37:0] port;
        string tag;
        #1;
        for (int d = 0; d < 2; d++) begin
            tag = (d == 0) ? "rr" : "fp";
            m_grant[d] = rst_n ? model_pick(d) : -1;
            exp_rdy = (m_grant[d] >= 0) ? 3'(1 << m_grant[d]) : 3'b000;
            exp_busy = {m_pending[d][rs2], m_pending[d][rs1]};
            check({tag, " ready"}, 32'(dut_ready(d)), 32'(exp_rdy));
            check({tag, " busy"}, 32'(dut_busy(d)), 32'(exp_busy));
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                m_pending[d] = '0;
                m_ptr[d]     = 0;
                m_wr_en[d]   = 1'b0;
                m_addr[d]    = '0;
                m_data[d]    = '0;
            end else begin
                if (m_grant[d] >= 0) begin
                    m_wr_en[d] = (rd[m_grant[d]] != 0);
                    m_addr[d]  = rd[m_grant[d]];
                    m_data[d]  = data[m_grant[d]];
                    if (d == 0) m_ptr[0] = (m_grant[d] + 1) % 3;
                end else begin
                    m_wr_en[d] = 1'b0;
                end
                if (flush) begin
                    m_pending[d] = '0;
                end else begin
                    if (m_grant[d] >= 0 && rd[m_grant[d]] != 0) m_pending[d][rd[m_grant[d]]] = 1'b0;
                    if (issue_v && issue_rd != 0) m_pending[d][issue_rd] = 1'b1;
                end
            end
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            tag = (d == 0) ? "rr" : "fp";
            port = dut_port(d);
            check({tag, " wr_en"}, 32'(port[37]), 32'(m_wr_en[d]));
            check({tag, " rd_addr"}, 32'(port[36:32]), 32'(m_addr[d]));
            check({tag, " rd_data"}, port[31:0], m_data[d]);
        end
        check("rr rr_ptr", 32'(if_rr.dbg_rr_ptr), 32'(m_ptr[0]));
        @(negedge clk);
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        bit        rst_n;
        bit [2:0]  v;       // {csr, lsu, alu}
        bit [4:0]  ard, lrd, crd;
        bit [31:0] adat, ldat, cdat;
        bit        iv;
        bit [4:0]  ird;
        bit        fl;
        bit [4:0]  rs1, rs2;
        bit [2:0]  rdy_rr, rdy_fp;
        bit [1:0]  busy;    // {rs2, rs1} on the round-robin instance
        bit        wr_en;   // round-robin write port after the edge
        bit [4:0]  addr;
        bit [31:0] wdata;
    } vec_t;

    vec_t vecs [21];

    initial begin
        // Reset with all sources requesting: no ready, idle port.
        vecs[0]  = '{0, 3'b111, 5, 6, 7, 'h11, 'h22, 'h33, 0, 0, 0, 5, 6, 3'b000, 3'b000, 2'b00, 0, 0, 'h0};
        vecs[1]  = '{0, 3'b111, 5, 6, 7, 'h11, 'h22, 'h33, 0, 0, 0, 5, 6, 3'b000, 3'b000, 2'b00, 0, 0, 'h0};
        // Round-robin rotation ALU, LSU, CSR, ALU; fixed priority stays on ALU.
        vecs[2]  = '{1, 3'b111, 5, 6, 7, 'h11, 'h22, 'h33, 0, 0, 0, 5, 6, 3'b001, 3'b001, 2'b00, 1, 5, 'h11};
        vecs[3]  = '{1, 3'b111, 5, 6, 7, 'h11, 'h22, 'h33, 0, 0, 0, 5, 6, 3'b010, 3'b001, 2'b00, 1, 6, 'h22};
        vecs[4]  = '{1, 3'b111, 5, 6, 7, 'h11, 'h22, 'h33, 0, 0, 0, 5, 6, 3'b100, 3'b001, 2'b00, 1, 7, 'h33};
        vecs[5]  = '{1, 3'b111, 5, 6, 7, 'h11, 'h22, 'h33, 0, 0, 0, 5, 6, 3'b001, 3'b001, 2'b00, 1, 5, 'h11};
        // ALU and CSR together for three cycles.
        vecs[6]  = '{1, 3'b101, 5, 6, 7, 'h11, 'h22, 'h33, 0, 0, 0, 5, 6, 3'b100, 3'b001, 2'b00, 1, 7, 'h33};
        vecs[7]  = '{1, 3'b101, 5, 6, 7, 'h11, 'h22, 'h33, 0, 0, 0, 5, 6, 3'b001, 3'b001, 2'b00, 1, 5, 'h11};
        vecs[8]  = '{1, 3'b101, 5, 6, 7, 'h11, 'h22, 'h33, 0, 0, 0, 5, 6, 3'b100, 3'b001, 2'b00, 1, 7, 'h33};
        // Issue x10, then LSU completes it.
        vecs[9]  = '{1, 3'b000, 5, 6, 7, 'h11, 'h22, 'h33, 1, 10, 0, 10, 0, 3'b000, 3'b000, 2'b00, 0, 7, 'h33};
        vecs[10] = '{1, 3'b010, 5, 10, 7, 'h11, 'hDEADBEEF, 'h33, 0, 0, 0, 10, 0, 3'b010, 3'b010, 2'b01, 1, 10, 'hDEADBEEF};
        vecs[11] = '{1, 3'b000, 5, 6, 7, 'h11, 'h22, 'h33, 0, 0, 0, 10, 0, 3'b000, 3'b000, 2'b00, 0, 10, 'hDEADBEEF};
        // Same-cycle issue and writeback of x3: bit stays set.
        vecs[12] = '{1, 3'b001, 3, 6, 7, 'h44, 'h22, 'h33, 1, 3, 0, 3, 0, 3'b001, 3'b001, 2'b00, 1, 3, 'h44};
        vecs[13] = '{1, 3'b000, 5, 6, 7, 'h11, 'h22, 'h33, 0, 0, 0, 3, 0, 3'b000, 3'b000, 2'b01, 0, 3, 'h44};
        // Issue to x0 sets nothing; CSR writeback to x0 is accepted without a write.
        vecs[14] = '{1, 3'b000, 5, 6, 7, 'h11, 'h22, 'h33, 1, 0, 0, 0, 3, 3'b000, 3'b000, 2'b10, 0, 3, 'h44};
        vecs[15] = '{1, 3'b100, 5, 6, 0, 'h11, 'h22, 'h55, 0, 0, 0, 3, 0, 3'b100, 3'b100, 2'b01, 0, 0, 'h55};
        // Build pending {3,4,9}, then flush alongside issue x12 and a write of x4.
        vecs[16] = '{1, 3'b000, 5, 6, 7, 'h11, 'h22, 'h33, 1, 4, 0, 3, 0, 3'b000, 3'b000, 2'b01, 0, 0, 'h55};
        vecs[17] = '{1, 3'b000, 5, 6, 7, 'h11, 'h22, 'h33, 1, 9, 0, 4, 9, 3'b000, 3'b000, 2'b01, 0, 0, 'h55};
        vecs[18] = '{1, 3'b001, 4, 6, 7, 'h66, 'h22, 'h33, 1, 12, 1, 4, 9, 3'b001, 3'b001, 2'b11, 1, 4, 'h66};
        vecs[19] = '{1, 3'b000, 5, 6, 7, 'h11, 'h22, 'h33, 0, 0, 0, 4, 12, 3'b000, 3'b000, 2'b00, 0, 4, 'h66};
        vecs[20] = '{1, 3'b000, 5, 6, 7, 'h11, 'h22, 'h33, 0, 0, 0, 3, 9, 3'b000, 3'b000, 2'b00, 0, 4, 'h66};
    end

    // ---------------- driver tasks ----------------
    task automatic drive_vec(input vec_t t);
        rst_n    = t.rst_n;
        valid    = t.v;
        rd[0]    = t.ard;
        rd[1]    = t.lrd;
        rd[2]    = t.crd;
        data[0]  = t.adat;
        data[1]  = t.ldat;
        data[2]  = t.cdat;
        issue_v  = t.iv;
        issue_rd = t.ird;
        flush    = t.fl;
        rs1      = t.rs1;
        rs2      = t.rs2;
    endtask

    task automatic drive_random();
        rst_n    = ($urandom_range(0, 49) != 0);
        valid    = 3'($urandom_range(0, 7));
        for (int k = 0; k < 3; k++) begin
            rd[k]   = 5'($urandom_range(0, 7));
            data[k] = $urandom;
        end
        issue_v  = ($urandom_range(0, 1) == 1);
        issue_rd = 5'($urandom_range(0, 7));
        flush    = ($urandom_range(0, 19) == 0);
        rs1      = 5'($urandom_range(0, 7));
        rs2      = 5'($urandom_range(0, 7));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        drive_vec('{0, 3'b111, 5, 6, 7, 'h11, 'h22, 'h33, 0, 0, 0, 5, 6, 3'b000, 3'b000, 2'b00, 0, 0, 'h0});
        // Bring every register out of X before the first comparison.
        @(posedge clk);
        model_reset();
        @(negedge clk);

        for (int i = 0; i < 21; i++) begin
            drive_vec(vecs[i]);
            #1;
            check($sformatf("vec%0d rr ready", i), 32'(dut_ready(0)), 32'(vecs[i].rdy_rr));
            check($sformatf("vec%0d fp ready", i), 32'(dut_ready(1)), 32'(vecs[i].rdy_fp));
            check($sformatf("vec%0d rr busy", i), 32'(dut_busy(0)), 32'(vecs[i].busy));
            step();
            check($sformatf("vec%0d rr port", i), 32'(dut_port(0) >> 32), 32'({vecs[i].wr_en, vecs[i].addr}));
            check($sformatf("vec%0d rr data", i), dut_port(0)[31:0], vecs[i].wdata);
        end

        for (int i = 0; i < 400; i++) begin
            drive_random();
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
